// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes, FSM state codes and the decoded instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] IMM_SIGN = 2'd0;
  localparam logic [1:0] IMM_ZERO = 2'd1;
  localparam logic [1:0] IMM_LUI  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Exactly one member is set for any instruction word.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic addi;
    logic ori;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational decode of an instruction word into a one-hot class plus the
// ALU operation implied by an R-type funct field.
module instr_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  i_instr,
  output instr_class_t o_class,
  output logic [2:0]   o_rtype_alu_op
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    o_class        = '0;
    o_rtype_alu_op = ALU_ADD;
    case (w_opcode)
      OP_RTYPE: begin
        if (i_instr == 32'h0000_0000) begin
          o_class.nop = 1'b1;
        end else begin
          case (w_funct)
            FN_ADD, FN_ADDU: begin
              o_class.rtype  = 1'b1;
              o_rtype_alu_op = ALU_ADD;
            end
            FN_SUB, FN_SUBU: begin
              o_class.rtype  = 1'b1;
              o_rtype_alu_op = ALU_SUB;
            end
            FN_AND: begin
              o_class.rtype  = 1'b1;
              o_rtype_alu_op = ALU_AND;
            end
            FN_OR: begin
              o_class.rtype  = 1'b1;
              o_rtype_alu_op = ALU_OR;
            end
            FN_SLT: begin
              o_class.rtype  = 1'b1;
              o_rtype_alu_op = ALU_SLT;
            end
            FN_JR:   o_class.jr      = 1'b1;
            default: o_class.illegal = 1'b1;
          endcase
        end
      end
      OP_LW:   o_class.lw      = 1'b1;
      OP_SW:   o_class.sw      = 1'b1;
      OP_BEQ:  o_class.beq     = 1'b1;
      OP_ADDI: o_class.addi    = 1'b1;
      OP_ORI:  o_class.ori     = 1'b1;
      OP_LUI:  o_class.lui     = 1'b1;
      OP_J:    o_class.j       = 1'b1;
      OP_JAL:  o_class.jal     = 1'b1;
      default: o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with
// MEM_LAT-cycle memory accesses and drives all datapath enables and selects.
module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  PCSrc,
  output logic        RegDst,
  output logic        raWrite,
  output logic        PCtoReg,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal
);

  localparam int             CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  instr_class_t w_class;
  logic [2:0]   w_rtype_alu_op;
  logic         w_last;
  logic [2:0]   w_alu_op;
  logic         w_alu_src;
  logic [1:0]   w_imm_src;

  instr_class_dec u_dec (
    .i_instr        (instr),
    .o_class        (w_class),
    .o_rtype_alu_op (w_rtype_alu_op)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // NOTE: state and counter are sequential, so they are only ever updated
  // with non-blocking assignments; mixing in blocking ones creates races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        ST_FETCH: begin
          if (w_last) r_state <= ST_DECODE;
          else        r_cnt   <= r_cnt + 1'b1;
        end
        ST_DECODE: begin
          if (w_class.illegal && TRAP_ILLEGAL)
            r_state <= ST_HALT;
          else if (w_class.j || w_class.jal || w_class.jr || w_class.nop || w_class.illegal)
            r_state <= ST_FETCH;
          else
            r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_class.beq)                  r_state <= ST_FETCH;
          else if (w_class.lw || w_class.sw) r_state <= ST_MEM;
          else                              r_state <= ST_WB;
        end
        ST_MEM: begin
          if (w_last) r_state <= w_class.lw ? ST_WB : ST_FETCH;
          else        r_cnt   <= r_cnt + 1'b1;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // ALU operand/operation selection; instr is stable through the instruction,
  // so these hold their EXEC values through MEM and WB without registering.
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b0;
    w_imm_src = IMM_SIGN;
    if (w_class.rtype) begin
      w_alu_op = w_rtype_alu_op;
    end else if (w_class.beq) begin
      w_alu_op = ALU_SUB;
    end else if (w_class.ori) begin
      w_alu_src = 1'b1;
      w_imm_src = IMM_ZERO;
      w_alu_op  = ALU_OR;
    end else if (w_class.lui) begin
      w_alu_src = 1'b1;
      w_imm_src = IMM_LUI;
      w_alu_op  = ALU_OR;
    end else if (w_class.addi || w_class.lw || w_class.sw) begin
      w_alu_src = 1'b1;
    end
  end

  assign state = r_state;

  // Outputs are forced low while reset_n is asserted, even though the
  // registered state already reads FETCH.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    PCSrc    = PCSRC_PC4;
    RegDst   = 1'b0;
    raWrite  = 1'b0;
    PCtoReg  = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ImmSrc   = IMM_SIGN;
    ALUOp    = ALU_ADD;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_FETCH: begin
          if (w_last) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = PCSRC_PC4;
          end
        end
        ST_DECODE: begin
          if (w_class.j || w_class.jal) begin
            PCWrite  = 1'b1;
            PCSrc    = PCSRC_JUMP;
            retire   = 1'b1;
            RegWrite = w_class.jal;
            raWrite  = w_class.jal;
            PCtoReg  = w_class.jal;
          end else if (w_class.jr) begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_RS;
            retire  = 1'b1;
          end else if (w_class.nop) begin
            retire = 1'b1;
          end else if (w_class.illegal) begin
            retire = ~TRAP_ILLEGAL;
          end
        end
        ST_EXEC: begin
          ALUOp  = w_alu_op;
          ALUSrc = w_alu_src;
          ImmSrc = w_imm_src;
          if (w_class.beq) begin
            PCSrc   = PCSRC_BRANCH;
            PCWrite = zero;
            retire  = 1'b1;
          end
        end
        ST_MEM: begin
          ALUOp   = w_alu_op;
          ALUSrc  = w_alu_src;
          ImmSrc  = w_imm_src;
          MemRead = w_class.lw;
          if (w_class.sw && w_last) begin
            MemWrite = 1'b1;
            retire   = 1'b1;
          end
        end
        ST_WB: begin
          ALUOp    = w_alu_op;
          ALUSrc   = w_alu_src;
          ImmSrc   = w_imm_src;
          RegWrite = 1'b1;
          retire   = 1'b1;
          RegDst   = w_class.rtype;
          MemtoReg = w_class.lw;
        end
        ST_HALT: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
